// File: rtl/ldpc_loop_buffer.sv
// Frame loop buffer: data FIFO + control FIFO feed dout; each frame's control word becomes its status word. Optional stall_count under LDPC_LOOP_STALL_CNT_EN.
// Latency: 1 cycle din->dout when a control word is pending; status word valid 1 cycle after the tlast beat leaves.
// Backpressure: inputs ready while their FIFO has room; a tlast beat is withheld (HOLD) while the status register is still occupied.
module ldpc_loop_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int CTRL_WIDTH = 32,
  parameter int DATA_DEPTH = 64,
  parameter int CTRL_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_ctrl_tvalid,
  output logic                        s_ctrl_tready,
  input  logic [CTRL_WIDTH-1:0]       s_ctrl_tdata,
  input  logic                        s_din_tvalid,
  output logic                        s_din_tready,
  input  logic [DATA_WIDTH-1:0]       s_din_tdata,
  input  logic                        s_din_tlast,
  output logic                        m_status_tvalid,
  input  logic                        m_status_tready,
  output logic [CTRL_WIDTH-1:0]       m_status_tdata,
  output logic                        m_dout_tvalid,
  input  logic                        m_dout_tready,
  output logic [DATA_WIDTH-1:0]       m_dout_tdata,
  output logic                        m_dout_tlast,
  output logic [$clog2(DATA_DEPTH):0] data_count
`ifdef LDPC_LOOP_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_count
`endif
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int CAW = $clog2(CTRL_DEPTH);
  localparam logic [DAW:0] D_FULL = (DAW+1)'(DATA_DEPTH);
  localparam logic [CAW:0] C_FULL = (CAW+1)'(CTRL_DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, HOLD} state_t;

  logic [DATA_WIDTH-1:0] d_mem [DATA_DEPTH];
  logic [DATA_DEPTH-1:0] d_last_mem;
  logic [DAW-1:0]        d_wr_ptr, d_rd_ptr, d_rd_ptr_nxt;
  logic [DAW:0]          d_count_nxt, d_after_pop;

  logic [CTRL_WIDTH-1:0] c_mem [CTRL_DEPTH];
  logic [CAW-1:0]        c_wr_ptr, c_rd_ptr;
  logic [CAW:0]          c_count, c_count_nxt;

  logic [CTRL_WIDTH-1:0] status_q;
  logic                  status_vld, status_vld_nxt;
  logic                  rdy_en;
  logic                  head_last_nxt;
  state_t                state, state_nxt;

  logic d_push, d_pop, c_push, c_pop, status_drain;

  // Ready is held low for one cycle after reset so that no transfer overlaps it.
  assign s_din_tready    = rdy_en && (data_count < D_FULL);
  assign s_ctrl_tready   = rdy_en && (c_count < C_FULL);
  assign m_dout_tvalid   = (state == STREAM) && (data_count != '0);
  assign m_dout_tdata    = d_mem[d_rd_ptr];
  assign m_dout_tlast    = d_last_mem[d_rd_ptr];
  assign m_status_tvalid = status_vld;
  assign m_status_tdata  = status_q;

  assign d_push       = s_din_tvalid && s_din_tready;
  assign d_pop        = m_dout_tvalid && m_dout_tready;
  assign c_push       = s_ctrl_tvalid && s_ctrl_tready;
  assign c_pop        = d_pop && m_dout_tlast;
  assign status_drain = status_vld && m_status_tready;

  // State is chosen from next-cycle FIFO head and status occupancy, so a tlast
  // beat that must wait is never shown as valid and later withdrawn.
  always_comb begin
    d_after_pop    = data_count - (DAW+1)'(d_pop);
    d_count_nxt    = d_after_pop + (DAW+1)'(d_push);
    d_rd_ptr_nxt   = d_rd_ptr + DAW'(d_pop);
    c_count_nxt    = c_count + (CAW+1)'(c_push) - (CAW+1)'(c_pop);
    status_vld_nxt = c_pop || (status_vld && !status_drain);
    head_last_nxt  = (d_after_pop == '0) ? s_din_tlast : d_last_mem[d_rd_ptr_nxt];
    state_nxt      = STREAM;
    if (c_count_nxt == '0)
      state_nxt = IDLE;
    else if ((d_count_nxt != '0) && head_last_nxt && status_vld_nxt)
      state_nxt = HOLD;
  end

  always_ff @(posedge clk) begin
    if (d_push) begin
      d_mem[d_wr_ptr]      <= s_din_tdata;
      d_last_mem[d_wr_ptr] <= s_din_tlast;
    end
    if (c_push)
      c_mem[c_wr_ptr] <= s_ctrl_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_wr_ptr   <= '0;
      d_rd_ptr   <= '0;
      data_count <= '0;
      c_wr_ptr   <= '0;
      c_rd_ptr   <= '0;
      c_count    <= '0;
      status_vld <= 1'b0;
      status_q   <= '0;
      rdy_en     <= 1'b0;
      state      <= IDLE;
    end else begin
      rdy_en     <= 1'b1;
      data_count <= d_count_nxt;
      c_count    <= c_count_nxt;
      d_rd_ptr   <= d_rd_ptr_nxt;
      state      <= state_nxt;
      status_vld <= status_vld_nxt;
      if (d_push)
        d_wr_ptr <= d_wr_ptr + 1'b1;
      if (c_push)
        c_wr_ptr <= c_wr_ptr + 1'b1;
      if (c_pop) begin
        c_rd_ptr <= c_rd_ptr + 1'b1;
        status_q <= c_mem[c_rd_ptr];
      end
    end
  end

`ifdef LDPC_LOOP_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (m_dout_tvalid && !m_dout_tready && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ldpc_loop_buffer.sv
// Bench for ldpc_loop_buffer: frame table, directed corner cases and randomized traffic against a queue-based model.
module tb_ldpc_loop_buffer;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam int DD = 16;
  localparam int CD = 4;
  localparam int NRF = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_ctrl_tvalid = 1'b0;
  logic          s_ctrl_tready;
  logic [CW-1:0] s_ctrl_tdata = '0;
  logic          s_din_tvalid = 1'b0;
  logic          s_din_tready;
  logic [DW-1:0] s_din_tdata = '0;
  logic          s_din_tlast = 1'b0;
  logic          m_status_tvalid;
  logic          m_status_tready;
  logic [CW-1:0] m_status_tdata;
  logic          m_dout_tvalid;
  logic          m_dout_tready;
  logic [DW-1:0] m_dout_tdata;
  logic          m_dout_tlast;
  logic [$clog2(DD):0] data_count;
`ifdef LDPC_LOOP_STALL_CNT_EN
  logic [31:0]   stall_count;
`endif

  logic dout_rdy_cmd = 1'b1, stat_rdy_cmd = 1'b1, rand_rdy = 1'b0, rnd_d = 1'b1, rnd_s = 1'b1;
  assign m_dout_tready   = rand_rdy ? rnd_d : dout_rdy_cmd;
  assign m_status_tready = rand_rdy ? rnd_s : stat_rdy_cmd;

  always #5 clk = ~clk;

  ldpc_loop_buffer #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DATA_DEPTH(DD), .CTRL_DEPTH(CD)) dut (
    .clk(clk), .rst(rst),
    .s_ctrl_tvalid(s_ctrl_tvalid), .s_ctrl_tready(s_ctrl_tready), .s_ctrl_tdata(s_ctrl_tdata),
    .s_din_tvalid(s_din_tvalid), .s_din_tready(s_din_tready), .s_din_tdata(s_din_tdata), .s_din_tlast(s_din_tlast),
    .m_status_tvalid(m_status_tvalid), .m_status_tready(m_status_tready), .m_status_tdata(m_status_tdata),
    .m_dout_tvalid(m_dout_tvalid), .m_dout_tready(m_dout_tready), .m_dout_tdata(m_dout_tdata), .m_dout_tlast(m_dout_tlast),
    .data_count(data_count)
`ifdef LDPC_LOOP_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: beats and control words as plain queues in arrival order.
  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
  beat_t         din_q[$];
  logic [CW-1:0] ctrl_q[$];
  logic [CW-1:0] stat_q[$];
  int            model_cnt = 0;
  bit            post_rst = 1'b1;
  int            cyc = 0;
  int            dout_beats = 0, stat_seen = 0;
  int            last_tlast_cyc = 0, last_stat_cyc = 0;
  logic [CW-1:0] last_stat = '0;
  logic [DW-1:0] last_dout = '0;
  logic          prev_dv = 1'b0, prev_dx = 1'b0, prev_sv = 1'b0, prev_sx = 1'b0;
  logic [DW:0]   prev_dd = '0;
  logic [CW-1:0] prev_sd = '0;
  longint        stall_model = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rnd_d = ($urandom_range(0, 3) != 0);
    rnd_s = ($urandom_range(0, 2) != 0);
  end

  always @(negedge clk) begin
    beat_t b;
    chk("data_count", 64'(data_count), 64'(model_cnt));
    chk("din_tready", 64'(s_din_tready), 64'(!post_rst && (model_cnt < DD)));
    chk("ctrl_tready", 64'(s_ctrl_tready), 64'(!post_rst && (ctrl_q.size() < CD)));
    chk("status_tvalid", 64'(m_status_tvalid), 64'(stat_q.size() != 0));
    if (m_status_tvalid && stat_q.size() != 0)
      chk("status_tdata", 64'(m_status_tdata), 64'(stat_q[0]));
    if (ctrl_q.size() == 0)
      chk("idle_dout_tvalid", 64'(m_dout_tvalid), 64'(0));
    if (prev_dv && !prev_dx)
      chk("dout_stable", 64'({m_dout_tvalid, m_dout_tdata, m_dout_tlast}), 64'({1'b1, prev_dd}));
    if (prev_sv && !prev_sx)
      chk("status_stable", 64'({m_status_tvalid, m_status_tdata}), 64'({1'b1, prev_sd}));
`ifdef LDPC_LOOP_STALL_CNT_EN
    chk("stall_count", 64'(stall_count), 64'(stall_model));
`endif
    if (rst) begin
      din_q.delete(); ctrl_q.delete(); stat_q.delete();
      model_cnt = 0;
      stall_model = 0;
      prev_dv = 1'b0; prev_sv = 1'b0;
    end else begin
      if (m_dout_tvalid && !m_dout_tready && stall_model < 64'hFFFF_FFFF)
        stall_model++;
      if (m_dout_tvalid && m_dout_tready) begin
        if (din_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL dout_extra: got beat %0h required none", m_dout_tdata);
        end else begin
          b = din_q.pop_front();
          chk("dout_beat", 64'({m_dout_tdata, m_dout_tlast}), 64'(b));
          model_cnt--;
        end
        dout_beats++;
        last_dout = m_dout_tdata;
        if (m_dout_tlast) begin
          last_tlast_cyc = cyc;
          if (ctrl_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL tlast_no_ctrl: got tlast transfer required a pending control word");
          end else
            stat_q.push_back(ctrl_q.pop_front());
        end
      end
      if (m_status_tvalid && m_status_tready) begin
        if (stat_q.size() != 0) void'(stat_q.pop_front());
        stat_seen++;
        last_stat = m_status_tdata;
        last_stat_cyc = cyc;
      end
      if (s_din_tvalid && s_din_tready) begin
        din_q.push_back({s_din_tdata, s_din_tlast});
        model_cnt++;
      end
      if (s_ctrl_tvalid && s_ctrl_tready)
        ctrl_q.push_back(s_ctrl_tdata);
      prev_dv = m_dout_tvalid;  prev_dx = m_dout_tready;   prev_dd = {m_dout_tdata, m_dout_tlast};
      prev_sv = m_status_tvalid; prev_sx = m_status_tready; prev_sd = m_status_tdata;
    end
    post_rst = rst;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int t = 0;
    s_din_tvalid = 1'b1; s_din_tdata = d; s_din_tlast = l;
    @(negedge clk);
    while (!s_din_tready && t < 500) begin @(negedge clk); t++; end
    if (!s_din_tready) begin
      checks++; failures++;
      $display("FAIL din_accept: got no tready required acceptance of %0h", d);
    end
    tick();
    s_din_tvalid = 1'b0;
  endtask

  task automatic send_ctrl(input logic [CW-1:0] w);
    int t = 0;
    s_ctrl_tvalid = 1'b1; s_ctrl_tdata = w;
    @(negedge clk);
    while (!s_ctrl_tready && t < 500) begin @(negedge clk); t++; end
    if (!s_ctrl_tready) begin
      checks++; failures++;
      $display("FAIL ctrl_accept: got no tready required acceptance of %0h", w);
    end
    tick();
    s_ctrl_tvalid = 1'b0;
  endtask

  task automatic wait_stat(input int target, input string nm);
    int t = 0;
    while (stat_seen < target && t < 3000) begin @(negedge clk); t++; end
    if (stat_seen < target) begin
      checks++; failures++;
      $display("FAIL %s: got %0d status words required %0d", nm, stat_seen, target);
    end
    tick();
  endtask

  typedef struct {
    logic [CW-1:0] ctrl;
    int            nbeats;
    logic [DW-1:0] base;
    int            exp_beats;
    logic [CW-1:0] exp_stat;
    logic [DW-1:0] exp_last;
  } fvec_t;

  initial begin
    fvec_t vt[4];
    int s0, b0;
    int rlen[NRF];
    logic [CW-1:0] rctl[NRF];

    vt[0] = '{32'h5A5A_0003, 3,  32'h0000_0010, 3,  32'h5A5A_0003, 32'h0000_0012};
    vt[1] = '{32'h0000_0002, 1,  32'h0000_0100, 1,  32'h0000_0002, 32'h0000_0100};
    vt[2] = '{32'hFFFF_FFFF, 7,  32'h0000_0200, 7,  32'hFFFF_FFFF, 32'h0000_0206};
    vt[3] = '{32'h0000_0000, 16, 32'h0000_1000, 16, 32'h0000_0000, 32'h0000_100F};

    repeat (3) tick();
    @(negedge clk);
    chk("rst_dout_tvalid", 64'(m_dout_tvalid), 64'(0));
    chk("rst_status_tvalid", 64'(m_status_tvalid), 64'(0));
    chk("rst_din_tready", 64'(s_din_tready), 64'(0));
    chk("rst_ctrl_tready", 64'(s_ctrl_tready), 64'(0));
    chk("rst_data_count", 64'(data_count), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_din_tready", 64'(s_din_tready), 64'(1));
    chk("post_rst_ctrl_tready", 64'(s_ctrl_tready), 64'(1));
    tick();

    // Single frame pass-through with latency and status timing.
    s0 = stat_seen; b0 = dout_beats;
    send_ctrl(32'hA5A5_0001);
    send_beat(32'd0, 1'b0);
    @(negedge clk);
    chk("latency_dout_tvalid", 64'(m_dout_tvalid), 64'(1));
    chk("latency_dout_tdata", 64'(m_dout_tdata), 64'(0));
    tick();
    for (int j = 1; j < 4; j++) send_beat(DW'(j), j == 3);
    wait_stat(s0 + 1, "pass_status");
    repeat (5) tick();
    chk("pass_beats", 64'(dout_beats - b0), 64'(4));
    chk("pass_last_dout", 64'(last_dout), 64'(3));
    chk("pass_status_once", 64'(stat_seen - s0), 64'(1));
    chk("pass_status_word", 64'(last_stat), 64'(32'hA5A5_0001));
    chk("pass_status_cycle", 64'(last_stat_cyc - last_tlast_cyc), 64'(1));

    for (int i = 0; i < 4; i++) begin
      s0 = stat_seen; b0 = dout_beats;
      send_ctrl(vt[i].ctrl);
      for (int j = 0; j < vt[i].nbeats; j++) send_beat(vt[i].base + DW'(j), j == vt[i].nbeats - 1);
      wait_stat(s0 + 1, "vec_status");
      chk("vec_beats", 64'(dout_beats - b0), 64'(vt[i].exp_beats));
      chk("vec_status_word", 64'(last_stat), 64'(vt[i].exp_stat));
      chk("vec_last_dout", 64'(last_dout), 64'(vt[i].exp_last));
    end

    // Data without a control word waits at the head.
    s0 = stat_seen; b0 = dout_beats;
    for (int j = 0; j < 8; j++) send_beat(32'h3400 + DW'(j), j == 7);
    repeat (3) tick();
    @(negedge clk);
    chk("noctrl_dout_tvalid", 64'(m_dout_tvalid), 64'(0));
    chk("noctrl_data_count", 64'(data_count), 64'(8));
    tick();
    send_ctrl(32'h0000_0034);
    wait_stat(s0 + 1, "noctrl_status");
    chk("noctrl_beats", 64'(dout_beats - b0), 64'(8));

    // Full data FIFO with the sink stalled.
    s0 = stat_seen; b0 = dout_beats;
    dout_rdy_cmd = 1'b0;
    send_ctrl(32'h0000_0035);
    for (int j = 0; j < DD; j++) send_beat(32'h3500 + DW'(j), 1'b0);
    s_din_tvalid = 1'b1; s_din_tdata = 32'h3500 + DW'(DD); s_din_tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("full_din_tready", 64'(s_din_tready), 64'(0));
    chk("full_data_count", 64'(data_count), 64'(DD));
    tick();
    dout_rdy_cmd = 1'b1;
    send_beat(32'h3500 + DW'(DD), 1'b0);
    send_beat(32'h3500 + DW'(DD + 1), 1'b1);
    wait_stat(s0 + 1, "full_status");
    chk("full_beats", 64'(dout_beats - b0), 64'(DD + 2));

    // Status backpressure holds the second tlast beat.
    s0 = stat_seen; b0 = dout_beats;
    stat_rdy_cmd = 1'b0;
    send_ctrl(32'h11);
    send_ctrl(32'h22);
    send_beat(32'h10, 1'b0); send_beat(32'h11, 1'b1);
    send_beat(32'h20, 1'b0); send_beat(32'h21, 1'b1);
    repeat (10) tick();
    @(negedge clk);
    chk("hold_status_word", 64'(m_status_tdata), 64'(32'h11));
    chk("hold_dout_tvalid", 64'(m_dout_tvalid), 64'(0));
    chk("hold_data_count", 64'(data_count), 64'(1));
    tick();
    stat_rdy_cmd = 1'b1;
    wait_stat(s0 + 2, "hold_status");
    chk("hold_second_status", 64'(last_stat), 64'(32'h22));
    chk("hold_beats", 64'(dout_beats - b0), 64'(4));

    // Reset in the middle of a frame.
    dout_rdy_cmd = 1'b0;
    send_ctrl(32'h37);
    send_beat(32'h3700, 1'b0);
    send_beat(32'h3701, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_dout_tvalid", 64'(m_dout_tvalid), 64'(0));
    chk("midrst_status_tvalid", 64'(m_status_tvalid), 64'(0));
    chk("midrst_din_tready", 64'(s_din_tready), 64'(0));
    chk("midrst_ctrl_tready", 64'(s_ctrl_tready), 64'(0));
    chk("midrst_data_count", 64'(data_count), 64'(0));
    tick();
`ifdef LDPC_LOOP_STALL_CNT_EN
    send_ctrl(32'h36);
    send_beat(32'h3600, 1'b1);
    @(negedge clk);
    chk("stall_dout_tvalid", 64'(m_dout_tvalid), 64'(1));
    repeat (10) @(negedge clk);
    chk("stall_ten", 64'(stall_count), 64'(10));
    tick();
`endif
    s0 = stat_seen; b0 = dout_beats;
    dout_rdy_cmd = 1'b1;
    send_ctrl(32'h38);
    for (int j = 0; j < 3; j++) send_beat(32'h3800 + DW'(j), j == 2);
`ifdef LDPC_LOOP_STALL_CNT_EN
    wait_stat(s0 + 2, "midrst_status");
    chk("midrst_beats", 64'(dout_beats - b0), 64'(4));
`else
    wait_stat(s0 + 1, "midrst_status");
    chk("midrst_beats", 64'(dout_beats - b0), 64'(3));
`endif
    chk("midrst_status_word", 64'(last_stat), 64'(32'h38));

    // Randomized traffic with independent control/data arrival and random sinks.
    for (int f = 0; f < NRF; f++) begin
      rctl[f] = $urandom;
      rlen[f] = int'($urandom_range(1, 6));
    end
    s0 = stat_seen;
    rand_rdy = 1'b1;
    fork
      begin
        for (int f = 0; f < NRF; f++) begin
          repeat ($urandom_range(0, 4)) tick();
          send_ctrl(rctl[f]);
        end
      end
      begin
        for (int f = 0; f < NRF; f++)
          for (int j = 0; j < rlen[f]; j++) begin
            repeat ($urandom_range(0, 1)) tick();
            send_beat($urandom, j == rlen[f] - 1);
          end
      end
    join
    rand_rdy = 1'b0;
    wait_stat(s0 + NRF, "rand_status");
    repeat (3) tick();
    chk("rand_last_status", 64'(last_stat), 64'(rctl[NRF-1]));
    chk("end_din_empty", 64'(din_q.size()), 64'(0));
    chk("end_ctrl_empty", 64'(ctrl_q.size()), 64'(0));
    chk("end_stat_empty", 64'(stat_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ldpc_loop_buffer.md
LDPC_LOOP_BUFFER -- requirements
Module: ldpc_loop_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: width of the din/dout data path in bits.
REQ-002 SHALL have parameter CTRL_WIDTH, default 32: width of the control and status words in bits.
REQ-003 SHALL have parameter DATA_DEPTH, default 64: data FIFO entries; power of two, minimum 4.
REQ-004 SHALL have parameter CTRL_DEPTH, default 8: control FIFO entries; power of two, minimum 2.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have ports s_ctrl_tvalid, s_ctrl_tready and s_ctrl_tdata: input, output and input; widths 1, 1 and CTRL_WIDTH; per-frame encoder control word.
REQ-008 SHALL have ports s_din_tvalid, s_din_tready, s_din_tdata and s_din_tlast: input, output, input and input; widths 1, 1, DATA_WIDTH and 1; input data stream, with tlast marking the end of frame.
REQ-009 SHALL have ports m_status_tvalid, m_status_tready and m_status_tdata: output, input and output; widths 1, 1 and CTRL_WIDTH; per-frame decoder status word.
REQ-010 SHALL have ports m_dout_tvalid, m_dout_tready, m_dout_tdata and m_dout_tlast: output, input, output and output; widths 1, 1, DATA_WIDTH and 1; output data stream.
REQ-011 SHALL have port data_count, output, clog2(DATA_DEPTH)+1: current data FIFO occupancy.

Function
REQ-012 A transfer on any channel SHALL occur only when tvalid and tready are both high on a clk edge; once asserted, an output tvalid SHALL NOT deassert, and its data SHALL NOT change, until the transfer.
REQ-013 Data FIFO SHALL store {tdata, tlast}; s_din_tready SHALL be high iff data_count < DATA_DEPTH.
REQ-014 Control FIFO SHALL store tdata; s_ctrl_tready SHALL be high iff the control FIFO is not full.
REQ-015 Output latency SHALL be 1 cycle: an accepted beat into an empty FIFO with a control word pending SHALL raise m_dout_tvalid on the next cycle.
REQ-016 Frame FSM states SHALL be: IDLE (control FIFO empty), STREAM (control word at head) and HOLD (tlast beat at head while the status register is occupied and m_status_tready is low).
REQ-017 In IDLE, m_dout_tvalid SHALL be 0 regardless of data FIFO contents.
REQ-018 In STREAM, m_dout_tvalid SHALL equal data FIFO not-empty.
REQ-019 On a tlast transfer on dout, the control FIFO head SHALL be popped into the status register in the same cycle.
REQ-020 After a tlast transfer, the next state SHALL be IDLE if the control FIFO becomes empty, else STREAM.
REQ-021 In HOLD, m_dout_tvalid SHALL be 0; HOLD SHALL return to STREAM in the cycle in which the status handshake completes.
REQ-022 The status register SHALL be single-entry; it SHALL load when empty or when being drained in the same cycle; m_status_tdata SHALL equal the popped control word unmodified.
REQ-023 A simultaneous push and pop on either FIFO SHALL leave its count unchanged; pointers SHALL wrap modulo depth.
REQ-024 data_count SHALL be updated registered, 1 cycle after the handshake.
REQ-025 A frame with no control word SHALL stall at the head, with no data loss, until a control word arrives.

Reset
REQ-026 While rst is high: all FIFOs SHALL be emptied; the FSM SHALL be IDLE; the status register SHALL be invalid.
REQ-027 On the cycle after rst is sampled high: every tvalid, s_*_tready and data_count SHALL be 0.
REQ-028 s_din_tready and s_ctrl_tready SHALL go high on the first cycle after rst deasserts.
REQ-029 Reset mid-frame SHALL discard all partial frames; no residual beat or status word SHALL be emitted.

Configuration
REQ-030 With macro LDPC_LOOP_STALL_CNT_EN defined, output port stall_count (32 bits) SHALL count cycles with m_dout_tvalid=1 and m_dout_tready=0.
REQ-031 stall_count SHALL saturate at 0xFFFFFFFF and SHALL clear on rst.
REQ-032 Without LDPC_LOOP_STALL_CNT_EN, stall_count and its logic SHALL be absent, with no other behavioural difference.

Verification
REQ-033 Frame pass-through: 1 control word 0xA5A5_0001, 4 beats 0..3 with tlast on beat 3, both sinks ready -> dout shows 0..3 with tlast on beat 3; status shows 0xA5A5_0001 exactly once, in the cycle after the tlast transfer.
REQ-034 Missing control: 8 beats pushed, no control word -> m_dout_tvalid=0 and data_count=8; control then sent -> all 8 beats delivered in order.
REQ-035 Full data FIFO: m_dout_tready=0, DATA_DEPTH+2 beats offered -> s_din_tready low after DATA_DEPTH beats and data_count=DATA_DEPTH; drain -> no loss or duplication.
REQ-036 Status backpressure: two 2-beat frames with ctrl 0x11 and 0x22, m_status_tready=0 -> second tlast held in HOLD; raise m_status_tready -> status 0x11 then 0x22, and the second tlast is released.
REQ-037 Mid-frame reset: rst for 1 cycle after 2 of 5 beats -> outputs 0 next cycle; a new frame afterwards passes cleanly.
REQ-038 With LDPC_LOOP_STALL_CNT_EN: 10 stalled cycles with m_dout_tvalid=1 -> stall_count=10.
